load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encodings, Funct3 access-size codes and the data memory address width.
package lsu_pkg;

  localparam int MEM_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    RMW_RD = 3'd2,
    ST_WR  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction for loads and lane merging for sub-word stores.
// Byte offset 0 is word bits 31:24.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_val_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    byte_l = 8'h00;
    unique case (off_i)
      2'd0: byte_l = word_i[31:24];
      2'd1: byte_l = word_i[23:16];
      2'd2: byte_l = word_i[15:8];
      2'd3: byte_l = word_i[7:0];
      default: byte_l = 8'h00;
    endcase
    half_l = off_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_l[7]}}, byte_l};
      F3_BU:   load_o = {24'h000000, byte_l};
      F3_H:    load_o = {{16{half_l[15]}}, half_l};
      F3_HU:   load_o = {16'h0000, half_l};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B: begin
        unique case (off_i)
          2'd0: merge_o[31:24] = store_val_i[7:0];
          2'd1: merge_o[23:16] = store_val_i[7:0];
          2'd2: merge_o[15:8]  = store_val_i[7:0];
          2'd3: merge_o[7:0]   = store_val_i[7:0];
          default: merge_o = word_i;
        endcase
      end
      F3_H: begin
        if (off_i[1]) merge_o[15:0]  = store_val_i[15:0];
        else          merge_o[31:16] = store_val_i[15:0];
      end
      default: merge_o = store_val_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  input  logic                  Is_Load_In,
  input  logic                  Is_Store_In,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           Address_In,
  input  logic [31:0]           Store_Value,
  input  logic [4:0]            Rd_In,
  output logic [MEM_ADDR_W-1:0] Mem_Address,
  output logic [31:0]           Mem_Store_Data,
  input  logic [31:0]           Mem_Load_Data,
  output logic                  Mem_Is_Load,
  output logic                  Mem_Is_Store,
  output logic                  Result_Valid,
  output logic                  Result_Write,
  output logic [31:0]           Result_Data,
  output logic [4:0]            Result_Rd,
  output logic                  Misaligned,
  output logic                  Access_Fault
);

  lsu_state_e state_q, state_d;
  logic                  ready_q, ready_d;
  logic [MEM_ADDR_W-3:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           sv_q, sv_d;
  logic                  mem_ld_q, mem_ld_d;
  logic                  mem_st_q, mem_st_d;
  logic [31:0]           st_data_q, st_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_write_q, res_write_d;
  logic [31:0]           res_data_q, res_data_d;
  logic [4:0]            res_rd_q, res_rd_d;
  logic                  mis_q, mis_d;
  logic                  fault_q, fault_d;

  logic        accept;
  logic        f3_ok;
  logic        fault_acc;
  logic        mis_acc;
  logic        is_h;
  logic        is_w;
  logic [1:0]  off_acc;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  assign accept = Valid_In && ready_q && (Is_Load_In || Is_Store_In);
  assign f3_ok  = Is_Store_In ? store_f3_ok(Funct3) : load_f3_ok(Funct3);
  assign fault_acc = (|Address_In[31:MEM_ADDR_W]) || !f3_ok;
  assign is_h = (Funct3[1:0] == 2'b01);
  assign is_w = (Funct3 == F3_W);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_acc = !fault_acc &&
                   ((is_h && Address_In[0]) || (is_w && |Address_In[1:0]));
  assign off_acc = Address_In[1:0];
`else
  // Misaligned halves/words are silently aligned down.
  assign mis_acc = 1'b0;
  assign off_acc = is_w ? 2'b00 :
                   is_h ? {Address_In[1], 1'b0} : Address_In[1:0];
`endif

  lsu_lane_align u_lane (
    .word_i      (Mem_Load_Data),
    .off_i       (off_q),
    .funct3_i    (f3_q),
    .store_val_i (sv_q),
    .load_o      (lane_load),
    .merge_o     (lane_merge)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    sv_d        = sv_q;
    mem_ld_d    = 1'b0;
    mem_st_d    = 1'b0;
    st_data_d   = 32'h0;
    res_valid_d = 1'b0;
    res_write_d = 1'b0;
    res_data_d  = 32'h0;
    res_rd_d    = 5'd0;
    mis_d       = 1'b0;
    fault_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          waddr_d = Address_In[MEM_ADDR_W-1:2];
          off_d   = off_acc;
          f3_d    = Funct3;
          rd_d    = Rd_In;
          sv_d    = Store_Value;
          if (fault_acc || mis_acc) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            res_rd_d    = Rd_In;
            fault_d     = fault_acc;
            mis_d       = mis_acc;
          end else if (Is_Store_In && is_w) begin
            state_d   = ST_WR;
            mem_st_d  = 1'b1;
            st_data_d = Store_Value;
          end else if (Is_Store_In) begin
            state_d  = RMW_RD;
            mem_ld_d = 1'b1;
          end else begin
            state_d  = LD_REQ;
            mem_ld_d = 1'b1;
          end
        end
      end
      LD_REQ: begin
        state_d     = RESP;
        res_valid_d = 1'b1;
        res_write_d = 1'b1;
        res_data_d  = lane_load;
        res_rd_d    = rd_q;
      end
      RMW_RD: begin
        state_d   = ST_WR;
        mem_st_d  = 1'b1;
        st_data_d = lane_merge;
      end
      ST_WR: begin
        state_d     = RESP;
        res_valid_d = 1'b1;
        res_rd_d    = rd_q;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      waddr_q     <= '0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      rd_q        <= 5'd0;
      sv_q        <= 32'h0;
      mem_ld_q    <= 1'b0;
      mem_st_q    <= 1'b0;
      st_data_q   <= 32'h0;
      res_valid_q <= 1'b0;
      res_write_q <= 1'b0;
      res_data_q  <= 32'h0;
      res_rd_q    <= 5'd0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      waddr_q     <= waddr_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      sv_q        <= sv_d;
      mem_ld_q    <= mem_ld_d;
      mem_st_q    <= mem_st_d;
      st_data_q   <= st_data_d;
      res_valid_q <= res_valid_d;
      res_write_q <= res_write_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
    end
  end

  assign Ready_Out      = ready_q;
  assign Mem_Address    = {waddr_q, 2'b00};
  assign Mem_Store_Data = st_data_q;
  assign Mem_Is_Load    = mem_ld_q;
  assign Mem_Is_Store   = mem_st_q;
  assign Result_Valid   = res_valid_q;
  assign Result_Write   = res_write_q;
  assign Result_Data    = res_data_q;
  assign Result_Rd      = res_rd_q;
  assign Misaligned     = mis_q;
  assign Access_Fault   = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic vs a byte-array model.
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid_In;
  logic        Ready_Out;
  logic        Is_Load_In;
  logic        Is_Store_In;
  logic [2:0]  Funct3;
  logic [31:0] Address_In;
  logic [31:0] Store_Value;
  logic [4:0]  Rd_In;
  logic [6:0]  Mem_Address;
  logic [31:0] Mem_Store_Data;
  logic [31:0] Mem_Load_Data;
  logic        Mem_Is_Load;
  logic        Mem_Is_Store;
  logic        Result_Valid;
  logic        Result_Write;
  logic [31:0] Result_Data;
  logic [4:0]  Result_Rd;
  logic        Misaligned;
  logic        Access_Fault;

  load_store_unit dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Valid_In       (Valid_In),
    .Ready_Out      (Ready_Out),
    .Is_Load_In     (Is_Load_In),
    .Is_Store_In    (Is_Store_In),
    .Funct3         (Funct3),
    .Address_In     (Address_In),
    .Store_Value    (Store_Value),
    .Rd_In          (Rd_In),
    .Mem_Address    (Mem_Address),
    .Mem_Store_Data (Mem_Store_Data),
    .Mem_Load_Data  (Mem_Load_Data),
    .Mem_Is_Load    (Mem_Is_Load),
    .Mem_Is_Store   (Mem_Is_Store),
    .Result_Valid   (Result_Valid),
    .Result_Write   (Result_Write),
    .Result_Data    (Result_Data),
    .Result_Rd      (Result_Rd),
    .Misaligned     (Misaligned),
    .Access_Fault   (Access_Fault)
  );

  always #5 Clk = ~Clk;

  // Data memory seen by the DUT
  logic [7:0] mem [128];
  logic       fill;

  always @(posedge Clk) begin
    if (fill) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
    end else if (Mem_Is_Store) begin
      mem[{Mem_Address[6:2], 2'd0}] <= Mem_Store_Data[31:24];
      mem[{Mem_Address[6:2], 2'd1}] <= Mem_Store_Data[23:16];
      mem[{Mem_Address[6:2], 2'd2}] <= Mem_Store_Data[15:8];
      mem[{Mem_Address[6:2], 2'd3}] <= Mem_Store_Data[7:0];
    end
  end

  assign Mem_Load_Data = {mem[{Mem_Address[6:2], 2'd0}],
                          mem[{Mem_Address[6:2], 2'd1}],
                          mem[{Mem_Address[6:2], 2'd2}],
                          mem[{Mem_Address[6:2], 2'd3}]};

  // Reference memory contents, updated from the architectural rules
  logic [7:0] ref_mem [128];

  int          ld_tot = 0;
  int          st_tot = 0;
  int          both_cnt = 0;
  int          viol = 0;
  logic [31:0] st_data = 32'h0;
  logic [6:0]  st_addr = 7'h0;

  always @(negedge Clk) begin
    if (Mem_Is_Load) ld_tot++;
    if (Mem_Is_Store) begin
      st_tot++;
      st_data = Mem_Store_Data;
      st_addr = Mem_Address;
    end
    if (Mem_Is_Load && Mem_Is_Store) both_cnt++;
    if ((Misaligned || Access_Fault) && !Result_Valid) viol++;
    if (Result_Valid && (Mem_Is_Load || Mem_Is_Store)) viol++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sv,
                        input logic [4:0] rd, output logic [31:0] got);
    logic [6:0]  a;
    logic [6:0]  wa;
    logic [7:0]  b0, b1;
    logic [31:0] edata, eword;
    bit          h, w, unsup, fault, mis, ewr;
    int          lat, eld, est, cyc, ld0, st0;
    a     = addr[6:0];
    h     = (f3[1:0] == 2'b01);
    w     = (f3 == 3'b010);
    unsup = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    fault = (addr[31:7] != 25'd0) || unsup;
    mis   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = !fault && ((h && a[0]) || (w && a[1:0] != 2'd0));
`else
    if (h) a[0] = 1'b0;
    if (w) a[1:0] = 2'd0;
`endif
    wa    = {a[6:2], 2'd0};
    edata = 32'h0;
    eword = 32'h0;
    ewr   = 1'b0;
    eld   = 0;
    est   = 0;
    lat   = 1;
    if (!(fault || mis)) begin
      if (st) begin
        lat = w ? 2 : 3;
        eld = w ? 0 : 1;
        est = 1;
        if (w) begin
          for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = sv[31-8*k -: 8];
        end else if (h) begin
          ref_mem[int'(a)]     = sv[15:8];
          ref_mem[int'(a) + 1] = sv[7:0];
        end else begin
          ref_mem[int'(a)] = sv[7:0];
        end
        eword = {ref_mem[int'(wa)], ref_mem[int'(wa) + 1],
                 ref_mem[int'(wa) + 2], ref_mem[int'(wa) + 3]};
      end else begin
        lat = 2;
        eld = 1;
        ewr = 1'b1;
        b0  = ref_mem[int'(a)];
        b1  = (f3 == 3'b010 || h) ? ref_mem[int'(a) + 1] : 8'h00;
        case (f3)
          3'b000:  edata = $signed({b0, 24'h0}) >>> 24;
          3'b100:  edata = {24'h0, b0};
          3'b001:  edata = $signed({b0, b1, 16'h0}) >>> 16;
          3'b101:  edata = {16'h0, b0, b1};
          default: edata = {ref_mem[int'(a)], ref_mem[int'(a) + 1],
                            ref_mem[int'(a) + 2], ref_mem[int'(a) + 3]};
        endcase
      end
    end

    cyc = 0;
    while (!Ready_Out && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
    chk("ready_idle", 32'(Ready_Out), 32'd1);
    ld0 = ld_tot;
    st0 = st_tot;
    Valid_In    = 1'b1;
    Is_Load_In  = ld;
    Is_Store_In = st;
    Funct3      = f3;
    Address_In  = addr;
    Store_Value = sv;
    Rd_In       = rd;
    @(posedge Clk);
    @(negedge Clk);
    Valid_In    = 1'b0;
    Is_Load_In  = 1'($urandom);
    Is_Store_In = 1'($urandom);
    Funct3      = 3'($urandom);
    Address_In  = $urandom;
    Store_Value = $urandom;
    Rd_In       = 5'($urandom);
    chk("busy", 32'(Ready_Out), 32'd0);
    cyc = 1;
    while (!Result_Valid && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
    got = Result_Data;
    chk("latency", 32'(cyc), 32'(lat));
    chk("data", Result_Data, edata);
    chk("write", 32'(Result_Write), 32'(ewr));
    chk("rd", 32'(Result_Rd), 32'(rd));
    chk("misaligned", 32'(Misaligned), 32'(mis));
    chk("fault", 32'(Access_Fault), 32'(fault));
    chk("ld_strobes", 32'(ld_tot - ld0), 32'(eld));
    chk("st_strobes", 32'(st_tot - st0), 32'(est));
    if (est != 0) begin
      chk("st_word", st_data, eword);
      chk("st_addr", 32'(st_addr), 32'(wa));
    end
    @(negedge Clk);
    chk("valid_pulse", 32'(Result_Valid), 32'd0);
    chk("ready_back", 32'(Ready_Out), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          rv, st0, r;
    bit          ld, st;
    logic [31:0] addr;

    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
    Reset       = 1'b1;
    fill        = 1'b1;
    Valid_In    = 1'b0;
    Is_Load_In  = 1'b0;
    Is_Store_In = 1'b0;
    Funct3      = 3'd0;
    Address_In  = 32'h0;
    Store_Value = 32'h0;
    Rd_In       = 5'd0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(Ready_Out), 32'd1);
    chk("rst_valid", 32'(Result_Valid), 32'd0);
    chk("rst_strobes", 32'({Mem_Is_Load, Mem_Is_Store}), 32'd0);
    chk("rst_addr", 32'(Mem_Address), 32'd0);
    chk("rst_data", Result_Data, 32'd0);
    chk("rst_flags", 32'({Misaligned, Access_Fault, Result_Write}), 32'd0);
    Reset = 1'b0;
    fill  = 1'b0;
    @(negedge Clk);

    do_req(1, 0, 3'b010, 32'h10, 32'h0, 5'd1, got);
    chk("lw_10", got, 32'h10111213);
    do_req(1, 0, 3'b001, 32'h12, 32'h0, 5'd2, got);
    chk("lh_12", got, 32'h00001213);
    do_req(1, 0, 3'b100, 32'h13, 32'h0, 5'd3, got);
    chk("lbu_13", got, 32'h00000013);
    do_req(0, 1, 3'b000, 32'h21, 32'h000000F0, 5'd4, got);
    chk("sb_merge", st_data, 32'h20F02223);
    do_req(1, 0, 3'b000, 32'h21, 32'h0, 5'd5, got);
    chk("lb_21", got, 32'hFFFFFFF0);
    do_req(1, 0, 3'b100, 32'h21, 32'h0, 5'd6, got);
    chk("lbu_21", got, 32'h000000F0);
    do_req(1, 0, 3'b010, 32'h06, 32'h0, 5'd7, got);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_06", got, 32'h0);
`else
    chk("lw_06", got, 32'h04050607);
`endif
    do_req(1, 0, 3'b010, 32'h80, 32'h0, 5'd8, got);
    chk("lw_80", got, 32'h0);
    do_req(1, 0, 3'b011, 32'h10, 32'h0, 5'd9, got);
    chk("ld_f3_011", got, 32'h0);
    do_req(1, 1, 3'b001, 32'h42, 32'hCAFE8001, 5'd10, got);
    do_req(1, 0, 3'b101, 32'h42, 32'h0, 5'd11, got);
    chk("lhu_42", got, 32'h00008001);

    // Reset while the SH read-modify-write is reading
    Valid_In    = 1'b1;
    Is_Load_In  = 1'b0;
    Is_Store_In = 1'b1;
    Funct3      = 3'b001;
    Address_In  = 32'h30;
    Store_Value = 32'h0000ABCD;
    Rd_In       = 5'd12;
    @(posedge Clk);
    #2;
    Valid_In = 1'b0;
    chk("rmw_rd_load", 32'(Mem_Is_Load), 32'd1);
    st0   = st_tot;
    Reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(Ready_Out), 32'd1);
    chk("rst_mid_load", 32'(Mem_Is_Load), 32'd0);
    chk("rst_mid_valid", 32'(Result_Valid), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    rv = 0;
    repeat (4) begin
      @(negedge Clk);
      if (Result_Valid) rv++;
    end
    chk("rst_no_result", 32'(rv), 32'd0);
    chk("rst_no_store", 32'(st_tot - st0), 32'd0);
    do_req(1, 0, 3'b010, 32'h30, 32'h0, 5'd13, got);
    chk("lw_30", got, 32'h30313233);

    repeat (250) begin
      r    = int'($urandom_range(0, 9));
      ld   = (r < 5);
      st   = (r >= 4);
      addr = ($urandom_range(0, 11) == 0) ? $urandom
                                           : 32'($urandom_range(0, 127));
      do_req(ld, st, 3'($urandom_range(0, 7)), addr, $urandom,
             5'($urandom_range(0, 31)), got);
    end

    chk("both_strobes", 32'(both_cnt), 32'd0);
    chk("outside_resp", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
